// File: rtl/uart_tx_par_frame.sv
// UART transmit framer: start, LSB-first data, optional parity, 1-2 stops.
// Advances only on baud TICK; back-to-back frames with no idle gap.
module uart_tx_par_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  TICK,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_valid,
    input  logic                  PAR_EN,
    input  logic [1:0]            PAR_TYP,
    input  logic                  STOP2,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  par_bit
);

    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [IW-1:0]         r_idx, w_idx_nxt, w_idx_inc;
    logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
    logic                  r_par_en, w_par_en_nxt;
    logic                  r_stop2, w_stop2_nxt;
    logic                  r_tx, w_tx_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_par, w_par_nxt;
    logic                  w_par_calc;
    logic                  w_end;
    logic                  w_accept;

    always_comb begin
        case (PAR_TYP)
            2'b00:   w_par_calc = ^P_DATA;
            2'b01:   w_par_calc = ~^P_DATA;
            2'b10:   w_par_calc = 1'b1;
            default: w_par_calc = 1'b0;
        endcase
    end

    assign w_idx_inc = r_idx + 1'b1;

    // Final stop tick doubles as an accept slot for back-to-back frames.
    assign w_end = TICK &&
                   (((r_state == S_STOP1) && !r_stop2) ||
                    (r_state == S_STOP2));

    assign w_accept = TICK && DATA_valid &&
                      ((r_state == S_IDLE) || w_end);

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_data_nxt   = r_data;
        w_par_en_nxt = r_par_en;
        w_stop2_nxt  = r_stop2;
        w_tx_nxt     = r_tx;
        w_busy_nxt   = r_busy;
        w_par_nxt    = r_par;

        if (TICK) begin
            case (r_state)
                S_IDLE: begin
                    w_tx_nxt = 1'b1;
                end
                S_START: begin
                    w_tx_nxt    = r_data[0];
                    w_state_nxt = S_DATA;
                end
                S_DATA: begin
                    if (r_idx == LAST) begin
                        if (r_par_en) begin
                            w_tx_nxt    = r_par;
                            w_state_nxt = S_PARITY;
                        end else begin
                            w_tx_nxt    = 1'b1;
                            w_state_nxt = S_STOP1;
                        end
                    end else begin
                        w_tx_nxt  = r_data[w_idx_inc];
                        w_idx_nxt = w_idx_inc;
                    end
                end
                S_PARITY: begin
                    w_tx_nxt    = 1'b1;
                    w_state_nxt = S_STOP1;
                end
                S_STOP1: begin
                    if (r_stop2) begin
                        w_state_nxt = S_STOP2;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                    end
                end
                S_STOP2: begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_tx_nxt    = 1'b1;
                end
            endcase
        end

        if (w_accept) begin
            w_data_nxt   = P_DATA;
            w_par_en_nxt = PAR_EN;
            w_stop2_nxt  = STOP2;
            w_par_nxt    = w_par_calc;
            w_tx_nxt     = 1'b0;
            w_busy_nxt   = 1'b1;
            w_state_nxt  = S_START;
            w_idx_nxt    = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_data   <= '0;
            r_par_en <= 1'b0;
            r_stop2  <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_par    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_data   <= w_data_nxt;
            r_par_en <= w_par_en_nxt;
            r_stop2  <= w_stop2_nxt;
            r_tx     <= w_tx_nxt;
            r_busy   <= w_busy_nxt;
            r_par    <= w_par_nxt;
        end
    end

    assign TX_OUT  = r_tx;
    assign busy    = r_busy;
    assign par_bit = r_par;

endmodule

// File: tb/tb_uart_tx_par_frame.sv
// Directed bench for uart_tx_par_frame (8-bit and 5-bit instances).
// Expected bit sequences are hand-written, listed in transmit order.
module tb_uart_tx_par_frame;

    logic       clk = 1'b0;
    logic       rst, tick;
    logic [7:0] pd8;
    logic [4:0] pd5;
    logic       dv8, dv5;
    logic       pe, s2;
    logic [1:0] pt;
    logic       tx8, busy8, par8;
    logic       tx5, busy5, par5;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_par_frame #(.DATA_WIDTH(8)) u8 (
        .CLK(clk), .RST(rst), .TICK(tick),
        .P_DATA(pd8), .DATA_valid(dv8),
        .PAR_EN(pe), .PAR_TYP(pt), .STOP2(s2),
        .TX_OUT(tx8), .busy(busy8), .par_bit(par8)
    );

    uart_tx_par_frame #(.DATA_WIDTH(5)) u5 (
        .CLK(clk), .RST(rst), .TICK(tick),
        .P_DATA(pd5), .DATA_valid(dv5),
        .PAR_EN(pe), .PAR_TYP(pt), .STOP2(s2),
        .TX_OUT(tx5), .busy(busy5), .par_bit(par5)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after an edge; seq is read MSB-first over n bits.
    task automatic run_frame(input string tag, input bit sel,
                             input logic [8:0] d, input logic p_en,
                             input logic [1:0] p_typ, input logic st2,
                             input logic [15:0] seq, input int n,
                             input logic exp_par);
        tick = 1'b1;
        pe   = p_en;
        pt   = p_typ;
        s2   = st2;
        if (sel) begin
            pd5 = d[4:0];
            dv5 = 1'b1;
        end else begin
            pd8 = d[7:0];
            dv8 = 1'b1;
        end
        step();
        dv8 = 1'b0;
        dv5 = 1'b0;
        check({tag, "_par"}, sel ? par5 : par8, exp_par);
        for (int i = 0; i < n; i++) begin
            check({tag, "_tx"}, sel ? tx5 : tx8, seq[n-1-i]);
            check({tag, "_busy"}, sel ? busy5 : busy8, 1);
            step();
        end
        check({tag, "_end_busy"}, sel ? busy5 : busy8, 0);
        check({tag, "_end_tx"}, sel ? tx5 : tx8, 1);
    endtask

    initial begin
        logic [19:0] b2b;
        logic [10:0] tg;
        rst  = 1'b1;
        tick = 1'b1;
        pd8  = '0;
        pd5  = '0;
        dv8  = 1'b0;
        dv5  = 1'b0;
        pe   = 1'b0;
        pt   = 2'b00;
        s2   = 1'b0;
        step();
        step();
        check("rst_tx", tx8, 1);
        check("rst_busy", busy8, 0);
        check("rst_par", par8, 0);
        check("rst_tx5", tx5, 1);
        rst = 1'b0;

        // Abort a frame mid-flight with a 3-cycle reset.
        pd8 = 8'h07;
        pe  = 1'b1;
        dv8 = 1'b1;
        step();
        dv8 = 1'b0;
        check("pre_rst_par", par8, 1);
        check("pre_rst_busy", busy8, 1);
        repeat (3) step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_rst_tx", tx8, 1);
            check("mid_rst_busy", busy8, 0);
            check("mid_rst_par", par8, 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("idle_tx", tx8, 1);
            check("idle_busy", busy8, 0);
            check("idle_par", par8, 0);
        end

        run_frame("even_a5", 0, 9'h0A5, 1, 2'b00, 0,
                  16'b01010010101, 11, 0);
        run_frame("odd_07", 0, 9'h007, 1, 2'b01, 0,
                  16'b01110000001, 11, 0);
        run_frame("even_07", 0, 9'h007, 1, 2'b00, 0,
                  16'b01110000011, 11, 1);
        run_frame("mark_07", 0, 9'h007, 1, 2'b10, 0,
                  16'b01110000011, 11, 1);
        run_frame("space_07", 0, 9'h007, 1, 2'b11, 0,
                  16'b01110000001, 11, 0);
        run_frame("w5_1f", 1, 9'h01F, 0, 2'b00, 1,
                  16'b01111111, 8, 1);

        // Back-to-back: 0x55 then 0xAA, no parity, one stop.
        b2b = 20'b0101010101_0010101011;
        pe  = 1'b0;
        s2  = 1'b0;
        pt  = 2'b00;
        pd8 = 8'h55;
        dv8 = 1'b1;
        step();
        pd8 = 8'hAA;
        for (int i = 0; i < 20; i++) begin
            check("b2b_tx", tx8, b2b[19-i]);
            check("b2b_busy", busy8, 1);
            if (i == 10) dv8 = 1'b0;
            step();
        end
        check("b2b_end_busy", busy8, 0);

        // Tick every 4 cycles; request raised on a non-tick cycle.
        tg   = 11'b00011110001;
        pe   = 1'b1;
        pt   = 2'b00;
        tick = 1'b0;
        pd8  = 8'h3C;
        dv8  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("gate_noacc_busy", busy8, 0);
            check("gate_noacc_tx", tx8, 1);
        end
        tick = 1'b1;
        step();
        tick = 1'b0;
        dv8  = 1'b0;
        pd8  = 8'hFF;
        pt   = 2'b01;
        check("gate_par", par8, 0);
        for (int j = 0; j < 44; j++) begin
            check("gate_tx", tx8, tg[10-(j/4)]);
            check("gate_busy", busy8, 1);
            tick = (j % 4 == 3);
            step();
        end
        check("gate_end_busy", busy8, 0);
        check("gate_end_tx", tx8, 1);
        tick = 1'b0;
        step();
        check("gate_hold_busy", busy8, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_par_frame.md
# uart_tx_par_frame

Parametrised UART transmit framer with integrated parity generation. It accepts a parallel word and serialises one frame on TX_OUT: start bit, DATA_WIDTH data bits LSB first, an optional parity bit and one or two stop bits. Parity mode (even/odd/mark/space) and stop-bit count are selectable per frame. It sits between the TX data source and the serial line, and advances on a baud tick enable.

## Interface
- DATA_WIDTH, 8: data bits per frame; legal range 5..9.
- CLK  in  1  single clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- TICK  in  1  baud enable; frame advances only on cycles with TICK=1 (tie high for one bit per clock).
- P_DATA  in  DATA_WIDTH  word to transmit; sampled on accept.
- DATA_valid  in  1  request; held by source until accepted.
- PAR_EN  in  1  1 = parity bit inserted; sampled on accept.
- PAR_TYP  in  2  00 even, 01 odd, 10 mark (1), 11 space (0); sampled on accept.
- STOP2  in  1  1 = two stop bits; sampled on accept.
- TX_OUT  out  1  registered serial line; idle high.
- busy  out  1  registered; high while a frame is in flight.
- par_bit  out  1  registered parity value of the last accepted frame (computed even if PAR_EN=0).

## Operation
- States: IDLE, START, DATA, PARITY, STOP1, STOP2. Bit index counter of $clog2(DATA_WIDTH) bits (minimum 1).
- Accept condition: state IDLE (or last stop tick, see below) and TICK=1 and DATA_valid=1. On accept: latch P_DATA, PAR_EN, STOP2; par_bit <= parity; TX_OUT <= 0; busy <= 1; state -> START; index <= 0.
- Parity: even = ^P_DATA; odd = ~^P_DATA; mark = 1; space = 0.
- On each TICK outside IDLE:
  - START: TX_OUT <= data[0]; -> DATA.
  - DATA, index < DATA_WIDTH-1: TX_OUT <= data[index+1]; index++.
  - DATA, index == DATA_WIDTH-1: PAR_EN latched ? (TX_OUT <= par_bit; -> PARITY) : (TX_OUT <= 1; -> STOP1).
  - PARITY: TX_OUT <= 1; -> STOP1.
  - STOP1: STOP2 latched ? (-> STOP2, TX_OUT stays 1) : end of frame.
  - STOP2: end of frame.
- End of frame: if DATA_valid=1 on that tick, back-to-back accept (same actions as accept; busy stays 1, no idle gap); else state -> IDLE, busy <= 0, TX_OUT stays 1.
- DATA_valid while busy (not on final stop tick) is ignored; P_DATA/config changes mid-frame have no effect.
- TICK=0: all state, TX_OUT, busy, index hold.

## Timing
- Reset values: TX_OUT=1, busy=0, par_bit=0, state IDLE, index 0, latched data/config 0. RST overrides TICK and DATA_valid; reset mid-frame aborts immediately, line returns high next cycle.
- Each bit on TX_OUT lasts exactly one tick interval (from the edge of one TICK cycle to the edge of the next).
- Latency: TX_OUT falls at the edge of the accepting TICK cycle.
- Frame length in ticks: 1 + DATA_WIDTH + PAR_EN + 1 + STOP2; busy high for exactly that many tick intervals (e.g. DATA_WIDTH=8, PAR_EN=1, STOP2=0, TICK=1 -> 11 cycles).
- Source handshake: request is consumed at the edge where busy rises (or the end-of-frame tick in back-to-back); source drops or updates DATA_valid the following cycle.

## Test plan
- Reset/idle: RST=1 for 3 cycles mid-frame, then release with DATA_valid=0 -> TX_OUT=1, busy=0, par_bit=0 held indefinitely.
- Even parity, TICK=1, P_DATA=0xA5, PAR_EN=1, PAR_TYP=00, STOP2=0 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1; par_bit=0; busy high 11 cycles.
- Odd/mark/space, P_DATA=0x07, PAR_EN=1 -> parity bit 0 (odd), 1 (even), 1 (mark), 0 (space); par_bit matches each.
- No parity, two stop bits, DATA_WIDTH=5, P_DATA=5'h1F, PAR_EN=0, STOP2=1 -> 0,1,1,1,1,1,1,1; busy high 8 cycles.
- Back-to-back: DATA_valid held with 0x55 then 0xAA -> second start bit immediately follows the stop bit, busy never drops between frames.
- Tick gating: TICK pulsed every 4 cycles, P_DATA=0x3C -> every bit lasts 4 cycles; DATA_valid asserted on a non-TICK cycle not accepted until the next TICK; P_DATA changed mid-frame does not alter transmitted bits.
